// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding, field-select constants and default terminal values for the stopwatch.
package stopwatch_pkg;
    localparam logic [1:0] ST_PAUSED = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_ADJUST = 2'd2;
    localparam logic       SEL_MIN   = 1'b0;
    localparam logic       SEL_SEC   = 1'b1;
    localparam int         DEF_MAX_MIN = 59;
    localparam int         DEF_MAX_SEC = 59;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: 6-bit up counter with synchronous clear; at_max lets the owner wrap before overflow.
module wrap_counter #(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    output logic [5:0] q,
    output logic       at_max
);
    logic [5:0] r_q;
    always_ff @(posedge clk) begin
        if (clr) r_q <= 6'd0;
        else if (inc) r_q <= r_q + 6'd1;
    end
    assign q      = r_q;
    assign at_max = r_q == 6'(MAX);
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: PAUSED/RUN/ADJUST sequencer owning min/sec registers.
// Define STOPWATCH_BLINK_EN to build the adjust-mode blink phase; otherwise blank outputs are tied low.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = DEF_MAX_MIN,
    parameter int MAX_SEC = DEF_MAX_SEC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_adj,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       running,
    output logic       blank_min,
    output logic       blank_sec
);
    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       w_sec_inc, w_min_inc, w_sec_max, w_min_max, w_run_tick, w_adj_tick;

    // adj beats pause_p; ADJUST always exits to PAUSED
    assign w_next = adj ? ST_ADJUST :
                    r_state == ST_ADJUST ? ST_PAUSED :
                    pause_p ? (r_state == ST_RUN ? ST_PAUSED : ST_RUN) : r_state;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_PAUSED;
        else r_state <= w_next;
    end

    assign w_run_tick = r_state == ST_RUN && tick_1hz;
    assign w_adj_tick = r_state == ST_ADJUST && tick_adj;
    assign w_sec_inc  = w_run_tick || (w_adj_tick && sel == SEL_SEC);
    assign w_min_inc  = (w_run_tick && w_sec_max) || (w_adj_tick && sel == SEL_MIN);
    assign running    = r_state == ST_RUN;

    // wrapping is a clear issued when incrementing at MAX, so MAX+1 never appears
    wrap_counter #(.MAX(MAX_SEC)) u_sec (
        .clk(clk), .clr(rst || (w_sec_inc && w_sec_max)), .inc(w_sec_inc), .q(sec), .at_max(w_sec_max)
    );
    wrap_counter #(.MAX(MAX_MIN)) u_min (
        .clk(clk), .clr(rst || (w_min_inc && w_min_max)), .inc(w_min_inc), .q(min), .at_max(w_min_max)
    );

`ifdef STOPWATCH_BLINK_EN
    logic r_phase, r_sel;
    // phase is forced low outside ADJUST and on any sel change, so a field is always shown first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_sel   <= SEL_MIN;
        end else begin
            r_sel   <= sel;
            r_phase <= (w_next != ST_ADJUST || sel != r_sel) ? 1'b0 : r_phase ^ w_adj_tick;
        end
    end
    assign blank_min = r_phase && r_sel == SEL_MIN;
    assign blank_sec = r_phase && r_sel == SEL_SEC;
`else
    assign blank_min = 1'b0;
    assign blank_sec = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed self-checking bench for stopwatch_ctrl.
module tb_stopwatch_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_adj = 1'b0;
    logic       pause_p = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [5:0] min, sec;
    logic       running, blank_min, blank_sec;
    int         n_cmp = 0;
    int         n_err = 0;

    stopwatch_ctrl dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj), .pause_p(pause_p),
        .adj(adj), .sel(sel), .min(min), .sec(sec), .running(running),
        .blank_min(blank_min), .blank_sec(blank_sec)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adj_ticks(input int n);
        tick_adj = 1'b1;
        repeat (n) cyc();
        tick_adj = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_p = 1'b1;
        cyc();
        pause_p = 1'b0;
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
    endtask

    initial begin
        int exp_blank;
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_min", min, 0);
        chk("rst_sec", sec, 0);
        chk("rst_running", running, 0);
        chk("rst_blank_min", blank_min, 0);
        chk("rst_blank_sec", blank_sec, 0);
        pulse_tick();
        chk("paused_hold", sec, 0);
        pulse_pause();
        chk("start_running", running, 1);
        for (int i = 1; i <= 3; i++) begin
            pulse_tick();
            chk("run_sec", sec, i);
        end
        chk("run_min", min, 0);
        adj = 1'b1;
        sel = 1'b1;
        cyc();
        chk("adj_running", running, 0);
        adj_ticks(56);
        chk("preload_sec59", sec, 59);
        adj = 1'b0;
        cyc();
        pulse_pause();
        pulse_tick();
        chk("carry_min", min, 1);
        chk("carry_sec", sec, 0);
        adj = 1'b1;
        sel = 1'b0;
        cyc();
        adj_ticks(58);
        chk("preload_min59", min, 59);
        sel = 1'b1;
        adj_ticks(59);
        chk("preload_sec59b", sec, 59);
        adj = 1'b0;
        cyc();
        pulse_pause();
        pulse_tick();
        chk("wrap_min", min, 0);
        chk("wrap_sec", sec, 0);
        chk("wrap_running", running, 1);
        pause_p = 1'b1;
        tick_1hz = 1'b1;
        cyc();
        chk("run_pt_sec", sec, 1);
        chk("run_pt_running", running, 0);
        cyc();
        pause_p = 1'b0;
        tick_1hz = 1'b0;
        chk("pause_pt_sec", sec, 1);
        chk("pause_pt_running", running, 1);
        adj = 1'b1;
        sel = 1'b1;
        cyc();
        adj_ticks(59);
        chk("adj_sec_zero", sec, 0);
        adj_ticks(62);
        chk("adj62_sec", sec, 2);
        chk("adj62_min", min, 0);
        tick_1hz = 1'b1;
        pause_p = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        pause_p = 1'b0;
        chk("adj_ignore_sec", sec, 2);
        chk("adj_ignore_running", running, 0);
        adj = 1'b0;
        cyc();
        chk("adj_exit_running", running, 0);
        pulse_tick();
        chk("adj_exit_hold", sec, 2);
        sel = 1'b0;
        adj = 1'b1;
        cyc();
        chk("blink_enter", blank_min, 0);
        for (int i = 0; i < 4; i++) begin
            adj_ticks(1);
`ifdef STOPWATCH_BLINK_EN
            exp_blank = (i % 2 == 0) ? 1 : 0;
`else
            exp_blank = 0;
`endif
            chk("blink_min", blank_min, exp_blank);
            chk("blink_sec", blank_sec, 0);
        end
        chk("blink_min_count", min, 4);
        adj_ticks(8);
        sel = 1'b1;
        adj_ticks(32);
        chk("pre_rst_min", min, 12);
        chk("pre_rst_sec", sec, 34);
        rst = 1'b1;
        adj = 1'b0;
        cyc();
        rst = 1'b0;
        chk("mid_rst_min", min, 0);
        chk("mid_rst_sec", sec, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_blank_min", blank_min, 0);
        chk("mid_rst_blank_sec", blank_sec, 0);
        pulse_pause();
        chk("post_rst_start", running, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
